// File: rtl/shift_sched_pkg.sv
// Shared encodings for the shift sequencer: FSM states, core limits and
// the direction/fill codes carried with each request.
package shift_sched_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int STEP_MAX = 7;
    localparam int W        = 8;

    localparam logic DIR_LEFT   = 1'b1;
    localparam logic DIR_RIGHT  = 1'b0;
    localparam logic FILL_LOG   = 1'b0;
    localparam logic FILL_ARITH = 1'b1;

endpackage

// File: rtl/bshift_core.sv
// Single-cycle 8-bit barrel shifter built from 1/2/4-bit mux stages;
// right shifts fill with the sign bit when arithmetic, left shifts fill with zero.
module bshift_core
    import shift_sched_pkg::*;
(
    input  logic [7:0] din,
    input  logic [2:0] shamt,
    input  logic       lr,
    input  logic       al,
    output logic [7:0] dout
);

    logic       fill;
    logic [7:0] s1;
    logic [7:0] s2;

    // The sign bit survives every right-shift stage, so one fill value serves all three.
    assign fill = (lr == DIR_RIGHT) && (al == FILL_ARITH) && din[7];

    assign s1   = !shamt[0] ? din :
                  (lr == DIR_LEFT) ? {din[6:0], 1'b0} : {fill, din[7:1]};
    assign s2   = !shamt[1] ? s1 :
                  (lr == DIR_LEFT) ? {s1[5:0], 2'b00} : {{2{fill}}, s1[7:2]};
    assign dout = !shamt[2] ? s2 :
                  (lr == DIR_LEFT) ? {s2[3:0], 4'b0000} : {{4{fill}}, s2[7:4]};

endmodule

// File: rtl/shift_sched.sv
// Round-robin front end that shares one 8-bit barrel core between two requesters,
// splitting long shifts into passes of at most STEP_MAX bits.
module shift_sched #(
    parameter int W        = 8,
    parameter int AW       = 5,
    parameter int STEP_MAX = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_din,
    input  logic [AW-1:0] req0_amt,
    input  logic          req0_lr,
    input  logic          req0_al,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_din,
    input  logic [AW-1:0] req1_amt,
    input  logic          req1_lr,
    input  logic          req1_al,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_dout,
    output logic          rsp_id
);
    import shift_sched_pkg::*;

    logic [1:0]    state;
    logic          rr;
    logic [W-1:0]  acc;
    logic [AW-1:0] rem;
    logic          lr_q;
    logic          al_q;
    logic          id_q;

    logic          grant0;
    logic          grant1;
    logic          idle;
    logic [AW-1:0] sel_amt;
    logic [2:0]    step;
    logic [AW-1:0] rem_next;
    logic [W-1:0]  core_out;

    // Requester 1 wins when it is alone or when both are pending and rr points at it.
    assign grant1     = req1_valid && (!req0_valid || rr);
    assign grant0     = req0_valid && !grant1;
    assign idle       = (state == IDLE);
    assign req0_ready = idle && grant0 && !rst;
    assign req1_ready = idle && grant1 && !rst;
    assign sel_amt    = grant1 ? req1_amt : req0_amt;

    // Whenever rem is within one pass its low three bits already hold the whole amount.
    assign step     = (rem > AW'(STEP_MAX)) ? 3'(STEP_MAX) : rem[2:0];
    assign rem_next = rem - {{(AW-3){1'b0}}, step};

    bshift_core u_core (
        .din   (acc),
        .shamt (step),
        .lr    (lr_q),
        .al    (al_q),
        .dout  (core_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr    <= 1'b0;
            acc   <= '0;
            rem   <= '0;
            lr_q  <= 1'b0;
            al_q  <= 1'b0;
            id_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        acc   <= grant1 ? req1_din : req0_din;
                        rem   <= sel_amt;
                        lr_q  <= grant1 ? req1_lr : req0_lr;
                        al_q  <= grant1 ? req1_al : req0_al;
                        id_q  <= grant1;
                        state <= (sel_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= core_out;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                        rr    <= !id_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_dout  = acc;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_sched.sv
// Randomized and directed bench for shift_sched: a transaction-level model predicts
// readies, response timing and shifted values, checked on every falling edge.
module tb_shift_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_din = 8'h00, req1_din = 8'h00;
    logic [4:0] req0_amt = 5'd0, req1_amt = 5'd0;
    logic       req0_lr = 1'b0, req1_lr = 1'b0;
    logic       req0_al = 1'b0, req1_al = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_dout;
    logic       rsp_id;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_din   (req0_din),
        .req0_amt   (req0_amt),
        .req0_lr    (req0_lr),
        .req0_al    (req0_al),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_din   (req1_din),
        .req1_amt   (req1_amt),
        .req1_lr    (req1_lr),
        .req1_al    (req1_al),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dout   (rsp_dout),
        .rsp_id     (rsp_id)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Full shift in one go, straight from the arithmetic meaning of each mode.
    function automatic logic [7:0] refShift(input logic [7:0] d, input int k, input logic lr, input logic al);
        logic signed [7:0] sd;
        sd = d;
        if (lr) return (k >= 8) ? 8'h00 : 8'(d << k);
        if (al) return (k >= 8) ? {8{d[7]}} : 8'(sd >>> k);
        return (k >= 8) ? 8'h00 : 8'(d >> k);
    endfunction

    function automatic logic winner(input logic v0, input logic v1, input logic rrp);
        if (v0 && v1) return rrp;
        return v1;
    endfunction

    // Transaction model: one job in flight, response due ceil(amt/7) cycles after accept.
    logic       m_busy = 1'b0;
    logic       m_rr   = 1'b0;
    logic       m_id   = 1'b0;
    int         m_cnt  = 0;
    int         m_lat  = 0;
    logic [7:0] m_exp  = 8'h00;
    logic       w;
    logic       exp_valid, exp_r0, exp_r1;

    assign w = winner(req0_valid, req1_valid, m_rr);

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rr   <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_id   <= w;
                m_lat  <= (int'(w ? req1_amt : req0_amt) + 6) / 7;
                m_exp  <= w ? refShift(req1_din, int'(req1_amt), req1_lr, req1_al)
                            : refShift(req0_din, int'(req0_amt), req0_lr, req0_al);
            end
        end else if (m_cnt >= m_lat) begin
            if (rsp_ready) begin
                m_busy <= 1'b0;
                m_rr   <= !m_id;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_valid = m_busy && (m_cnt >= m_lat);
            exp_r0    = !rst && !m_busy && req0_valid && (w == 1'b0);
            exp_r1    = !rst && !m_busy && req1_valid && (w == 1'b1);
            checkOutput("req0_ready", 32'(req0_ready), 32'(exp_r0));
            checkOutput("req1_ready", 32'(req1_ready), 32'(exp_r1));
            checkOutput("one_ready", 32'(req0_ready && req1_ready), 32'(0));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                checkOutput("rsp_dout", 32'(rsp_dout), 32'(m_exp));
                checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
            end
        end
    end

    task automatic setReq(input logic id, input logic v, input logic [7:0] d, input logic [4:0] k,
                          input logic lr, input logic al);
        if (id) begin
            req1_valid = v; req1_din = d; req1_amt = k; req1_lr = lr; req1_al = al;
        end else begin
            req0_valid = v; req0_din = d; req0_amt = k; req0_lr = lr; req0_al = al;
        end
    endtask

    // Issue one request, wait for its accept and response; called and returns #1 after a rising edge.
    task automatic applyStimulus(input logic id, input logic [7:0] d, input logic [4:0] k,
                                 input logic lr, input logic al,
                                 output int lat, output logic [7:0] dout, output logic rid);
        int guard;
        lat  = -1;
        dout = 8'h00;
        rid  = 1'b0;
        guard = 0;
        setReq(id, 1'b1, d, k, lr, al);
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checkOutput("accept_timeout", 32'(guard), 32'(0));
            setReq(id, 1'b0, d, k, lr, al);
            return;
        end
        @(posedge clk);
        #1;
        setReq(id, 1'b0, d, k, lr, al);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        dout = rsp_dout;
        rid  = rsp_id;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic id, input logic [7:0] d, input logic [4:0] k,
                            input logic lr, input logic al,
                            input logic [7:0] exp_d, input int exp_lat);
        int lat;
        logic [7:0] dout;
        logic rid;
        applyStimulus(id, d, k, lr, al, lat, dout, rid);
        checkOutput({name, "_dout"}, 32'(dout), 32'(exp_d));
        checkOutput({name, "_id"}, 32'(rid), 32'(id));
        checkOutput({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int n;
        int guard;
        logic [3:0] idv;
        logic [7:0] hold_d;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_valid", 32'(rsp_valid), 32'(0));
        checkOutput("rst_dout", 32'(rsp_dout), 32'(0));
        checkOutput("rst_id", 32'(rsp_id), 32'(0));
        checkOutput("rst_ready0", 32'(req0_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;

        directed("asr3",  1'b0, 8'h96, 5'd3,  1'b0, 1'b1, 8'hF2, 1);
        directed("lsr3",  1'b0, 8'h96, 5'd3,  1'b0, 1'b0, 8'h12, 1);
        directed("asr20", 1'b1, 8'h80, 5'd20, 1'b0, 1'b1, 8'hFF, 3);
        directed("shl7",  1'b0, 8'h01, 5'd7,  1'b1, 1'b0, 8'h80, 1);
        directed("shl9",  1'b0, 8'h01, 5'd9,  1'b1, 1'b0, 8'h00, 2);
        directed("amt0",  1'b0, 8'h5A, 5'd0,  1'b1, 1'b0, 8'h5A, 0);

        // Fairness from a fresh reset: both requesters pending forever.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        setReq(1'b0, 1'b1, 8'h11, 5'd3, 1'b0, 1'b0);
        setReq(1'b1, 1'b1, 8'h22, 5'd10, 1'b1, 1'b0);
        n = 0;
        guard = 0;
        idv = 4'b0000;
        while (n < 4 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (rsp_valid) begin
                idv[n] = rsp_id;
                n++;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("fair_count", n, 4);
        checkOutput("fair_order", 32'(idv), 32'(4'b1010));

        // Backpressure: response held for 4 cycles while req1 waits.
        rsp_ready = 1'b0;
        setReq(1'b0, 1'b1, 8'hC3, 5'd5, 1'b1, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!req0_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_accept", 32'(req0_ready), 32'(1));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        setReq(1'b1, 1'b1, 8'h0F, 5'd1, 1'b1, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        hold_d = rsp_dout;
        checkOutput("bp_dout", 32'(hold_d), 32'(8'h60));
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_hold_valid", 32'(rsp_valid), 32'(1));
            checkOutput("bp_hold_dout", 32'(rsp_dout), 32'(hold_d));
            checkOutput("bp_hold_id", 32'(rsp_id), 32'(0));
            checkOutput("bp_ready1", 32'(req1_ready), 32'(0));
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the second pass of an amt=20 request from requester 1.
        setReq(1'b1, 1'b1, 8'h80, 5'd20, 1'b0, 1'b1);
        guard = 0;
        @(negedge clk);
        while (!req1_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        setReq(1'b0, 1'b1, 8'h3C, 5'd2, 1'b1, 1'b0);
        setReq(1'b1, 1'b1, 8'h55, 5'd4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_valid", 32'(rsp_valid), 32'(0));
        checkOutput("abort_dout", 32'(rsp_dout), 32'(0));
        checkOutput("abort_id", 32'(rsp_id), 32'(0));
        checkOutput("abort_ready0", 32'(req0_ready), 32'(1));
        checkOutput("abort_ready1", 32'(req1_ready), 32'(0));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("fresh_lat", n, 1);
        checkOutput("fresh_dout", 32'(rsp_dout), 32'(8'hF0));
        checkOutput("fresh_id", 32'(rsp_id), 32'(0));
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_din   = 8'($urandom);
            req1_din   = 8'($urandom);
            req0_amt   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(0, 31));
            req1_amt   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(0, 31));
            req0_lr    = 1'($urandom);
            req1_lr    = 1'($urandom);
            req0_al    = 1'($urandom);
            req1_al    = 1'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
